// File: rtl/cordic_arb_pkg.sv
// Shared types and constants for the CORDIC request arbiter.
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OP_COS = 1'b0;
    localparam logic OP_SIN = 1'b1;

    localparam int OP_CNT_W = 16;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping modulo N_REQ.
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDW-1:0]   ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDW-1:0]   idx_o,
    output logic             any_o
);

    logic [IDW-1:0] cand;
    logic           found;

    // NOTE: every output and temporary gets a default before the loop, so no path leaves a value held and no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDW'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cordic_req_arbiter.sv
// Round-robin scheduler sharing one CORDIC core among N_REQ clients, one operation at a time.
module cordic_req_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ-1:0]      req_op,
    input  logic [N_REQ*W-1:0]    req_angle,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [W-1:0]          rsp_data,
    input  logic [N_REQ-1:0]      rsp_ack,
    output logic                  cordic_beg,
    output logic                  cordic_operation,
    output logic [W-1:0]          cordic_angle,
    input  logic                  cordic_ready,
    input  logic [W-1:0]          cordic_result,
    output logic                  cordic_ack,
    output logic                  busy,
    output logic [IDW-1:0]        grant_id,
    output logic [OP_CNT_W-1:0]   op_count
);

    arb_state_e            state_q, state_d;
    logic [IDW-1:0]        ptr_q, ptr_d;
    logic [IDW-1:0]        grant_id_q, grant_id_d;
    logic                  op_q, op_d;
    logic [W-1:0]          angle_q, angle_d;
    logic [W-1:0]          result_q, result_d;
    logic [OP_CNT_W-1:0]   op_count_q, op_count_d;

    logic [N_REQ-1:0]      pick_gnt;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_any;
    logic [IDW-1:0]        next_ptr;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign next_ptr = (grant_id_q == IDW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        op_d       = op_q;
        angle_d    = angle_q;
        result_d   = result_q;
        op_count_d = op_count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_idx;
                    op_d       = req_op[pick_idx];
                    angle_d    = req_angle[pick_idx*W +: W];
                    state_d    = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (cordic_ready) begin
                    result_d = cordic_result;
                    if (op_count_q != '1) op_count_d = op_count_q + 1'b1;
                    state_d  = ST_RESP;
                end
            end
            ST_RESP: begin
                // Only the owner's acknowledge releases the result; other bits are ignored.
                if (rsp_ack[grant_id_q]) begin
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            op_q       <= OP_COS;
            angle_q    <= '0;
            result_q   <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            op_q       <= op_d;
            angle_q    <= angle_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE) ? pick_gnt : '0;
    assign rsp_valid        = (state_q == ST_RESP) ? (N_REQ'(1) << grant_id_q) : '0;
    assign rsp_data         = result_q;
    assign cordic_beg       = (state_q == ST_START);
    assign cordic_operation = op_q;
    assign cordic_angle     = angle_q;
    assign cordic_ack       = (state_q == ST_WAIT) && cordic_ready;
    assign busy             = (state_q != ST_IDLE);
    assign grant_id         = grant_id_q;
    assign op_count         = op_count_q;

endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Directed bench for cordic_req_arbiter; the CORDIC core is played by hand-driven ready/result.
module tb_cordic_req_arbiter;
    import cordic_arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_op;
    logic [N*W-1:0]  req_angle;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [W-1:0]    rsp_data;
    logic [N-1:0]    rsp_ack;
    logic            cordic_beg;
    logic            cordic_operation;
    logic [W-1:0]    cordic_angle;
    logic            cordic_ready;
    logic [W-1:0]    cordic_result;
    logic            cordic_ack;
    logic            busy;
    logic [IDW-1:0]  grant_id;
    logic [15:0]     op_count;

    int vectors;
    int miscompares;
    int acks;

    cordic_req_arbiter #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_op           (req_op),
        .req_angle        (req_angle),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_ack          (rsp_ack),
        .cordic_beg       (cordic_beg),
        .cordic_operation (cordic_operation),
        .cordic_angle     (cordic_angle),
        .cordic_ready     (cordic_ready),
        .cordic_result    (cordic_result),
        .cordic_ack       (cordic_ack),
        .busy             (busy),
        .grant_id         (grant_id),
        .op_count         (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsp_ack   = '0;
        cordic_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // One full operation for the expected winner; requests stay as the caller set them.
    task automatic serve(input int exp_gid, input logic [W-1:0] result);
        settle();
        check("serve_req_ready", req_ready, 64'(1) << exp_gid);
        tick();
        settle();
        check("serve_beg", cordic_beg, 1);
        check("serve_grant_id", grant_id, exp_gid);
        tick();
        cordic_ready  = 1'b1;
        cordic_result = result;
        settle();
        check("serve_ack", cordic_ack, 1);
        tick();
        cordic_ready = 1'b0;
        settle();
        check("serve_rsp_valid", rsp_valid, 64'(1) << exp_gid);
        check("serve_rsp_data", rsp_data, result);
        rsp_ack = N'(1) << exp_gid;
        tick();
        rsp_ack = '0;
        settle();
        check("serve_idle", busy, 0);
    endtask

    initial begin
        int order2[5];
        int order3[4];
        order2 = '{0, 1, 2, 3, 0};
        order3 = '{0, 2, 0, 2};
        vectors       = 0;
        miscompares   = 0;
        req_op        = '0;
        req_angle     = '0;
        cordic_result = '0;
        do_reset();
        do_reset();
        settle();
        check("rst_busy", busy, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_op_count", op_count, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_beg_ack", {cordic_beg, cordic_ack}, 0);

        // Single request, core latency of 20 cycles.
        req_valid        = 4'b0001;
        req_angle[31:0]  = 32'h3F80_0000;
        settle();
        check("t1_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        settle();
        check("t1_beg", cordic_beg, 1);
        check("t1_op", cordic_operation, OP_COS);
        check("t1_angle", cordic_angle, 32'h3F80_0000);
        acks = int'(cordic_ack);
        tick();
        for (int i = 0; i < 18; i++) begin
            settle();
            acks += int'(cordic_ack);
            acks += int'(cordic_beg) * 100;
            tick();
        end
        check("t1_angle_stable", cordic_angle, 32'h3F80_0000);
        cordic_ready  = 1'b1;
        cordic_result = 32'h3F0A_5140;
        settle();
        acks += int'(cordic_ack);
        tick();
        cordic_ready = 1'b0;
        settle();
        acks += int'(cordic_ack);
        check("t1_rsp_valid", rsp_valid, 4'b0001);
        check("t1_rsp_data", rsp_data, 32'h3F0A_5140);
        check("t1_op_count", op_count, 1);
        tick();
        settle();
        check("t1_rsp_held", rsp_valid, 4'b0001);
        rsp_ack = 4'b0001;
        tick();
        rsp_ack = '0;
        settle();
        check("t1_idle_busy", busy, 0);
        check("t1_idle_rsp", rsp_valid, 0);
        check("t1_ack_pulses", acks, 1);

        // All four requesting from reset.
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) serve(order2[i], 32'h1000_0000 + i);
        req_valid = '0;
        check("t2_op_count", op_count, 5);

        // Two requesters alternate.
        do_reset();
        req_valid = 4'b0101;
        for (int i = 0; i < 4; i++) serve(order3[i], 32'h2000_0000 + i);
        req_valid = '0;

        // Foreign acknowledge ignored while client 1 owns the result.
        do_reset();
        req_valid        = 4'b0010;
        req_op[1]        = OP_SIN;
        req_angle[63:32] = 32'h4000_0000;
        settle();
        check("t4_req_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        settle();
        check("t4_op", cordic_operation, OP_SIN);
        check("t4_angle", cordic_angle, 32'h4000_0000);
        tick();
        cordic_ready  = 1'b1;
        cordic_result = 32'hBF00_0000;
        tick();
        cordic_ready = 1'b0;
        rsp_ack      = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("t4_rsp_valid", rsp_valid, 4'b0010);
            check("t4_rsp_data", rsp_data, 32'hBF00_0000);
            tick();
        end
        rsp_ack = 4'b0010;
        settle();
        check("t4_busy_before", busy, 1);
        tick();
        rsp_ack = '0;
        settle();
        check("t4_idle", busy, 0);

        // Reset in WAIT aborts the operation for client 3.
        req_valid          = 4'b1000;
        req_angle[127:96]  = 32'h3F00_0000;
        settle();
        check("t5_req_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("t5_busy", busy, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_grant_id", grant_id, 0);
        check("t5_op_count", op_count, 0);
        check("t5_angle", cordic_angle, 0);
        req_valid = 4'b0100;
        serve(2, 32'h3E00_0000);
        req_valid = '0;

        // Core holds ready for 4 cycles: one ack only.
        req_valid = 4'b0001;
        settle();
        check("t6_req_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        cordic_ready  = 1'b1;
        cordic_result = 32'h3E80_0000;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            settle();
            acks += int'(cordic_ack);
            tick();
        end
        cordic_ready = 1'b0;
        settle();
        check("t6_ack_pulses", acks, 1);
        check("t6_op_count", op_count, 2);
        check("t6_rsp_data", rsp_data, 32'h3E80_0000);
        rsp_ack = 4'b0001;
        tick();
        rsp_ack = '0;
        settle();
        check("t6_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
